// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: FSM state encoding, interrupt
// codes, mcause layout and the machine exception codes used by the core.
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER,
    ST_VECTOR,
    ST_RETURN,
    ST_RESUME
  } trap_state_e;

  // Machine interrupt codes (mcause[4:0] when the interrupt bit is set)
  localparam logic [4:0] IRQ_M_EXT   = 5'd11;
  localparam logic [4:0] IRQ_M_SW    = 5'd3;
  localparam logic [4:0] IRQ_M_TIMER = 5'd7;

  localparam int CAUSE_INTR_BIT = 31;

  // Synchronous exception codes
  localparam logic [4:0] EXC_INST_MISALIGNED  = 5'd0;
  localparam logic [4:0] EXC_INST_ACCESS      = 5'd1;
  localparam logic [4:0] EXC_ILLEGAL_INST     = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT       = 5'd3;
  localparam logic [4:0] EXC_LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] EXC_LOAD_ACCESS      = 5'd5;
  localparam logic [4:0] EXC_STORE_MISALIGNED = 5'd6;
  localparam logic [4:0] EXC_STORE_ACCESS     = 5'd7;
  localparam logic [4:0] EXC_ECALL_M          = 5'd11;

  // mcause value for an interrupt with the given code
  function automatic logic [31:0] irq_cause(input logic [4:0] code);
    logic [31:0] c;
    c = {27'b0, code};
    c[CAUSE_INTR_BIT] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// irq_sync: SYNC_STAGES-deep single-bit synchronizer for an asynchronous
// level input. Synchronous active-high reset clears every stage.
//   clk  in  clock
//   rst  in  synchronous reset, active high
//   d    in  asynchronous level
//   q    out synchronized level, SYNC_STAGES cycles behind d
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer in front of the machine-mode CSR file.
// Arbitrates synchronous exceptions, MRET and the three machine interrupts,
// and emits registered one-cycle pulses for trap entry/return plus the PC
// redirect request for the control unit.
//   clk, rst         clock, synchronous active-high reset
//   ext_irq          async external interrupt level (synchronized here)
//   sw_irq/timer_irq synchronous interrupt levels
//   irq_en           global interrupt enable (mstatus.MIE)
//   insn_boundary    pulse: interrupts may be taken this cycle
//   exc_valid/cause  pulse + code: synchronous exception
//   mret             pulse: MRET executing
//   trap_start/finish pulses to the CSR file, trap_cause = mcause
//   redirect/_sel    PC load pulse, source 0 = mtvec, 1 = mepc
//   busy             sequencer not idle; control unit stalls
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ext_irq,
  input  logic        sw_irq,
  input  logic        timer_irq,
  input  logic        irq_en,
  input  logic        insn_boundary,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic        mret,
  output logic        trap_start,
  output logic        trap_finish,
  output logic [31:0] trap_cause,
  output logic        redirect,
  output logic        redirect_sel,
  output logic        busy
);

  trap_state_e state, state_nxt;
  logic [31:0] cause_nxt;
  logic        ext_s;
  logic        irq_any;
  logic [4:0]  irq_code;

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_irq),
    .q   (ext_s)
  );

  // Fixed priority: external > software > timer
  always_comb begin
    irq_any  = ext_s | sw_irq | timer_irq;
    irq_code = IRQ_M_TIMER;
    if (ext_s)       irq_code = IRQ_M_EXT;
    else if (sw_irq) irq_code = IRQ_M_SW;
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = trap_cause;
    case (state)
      ST_IDLE: begin
        // Exception beats a simultaneous MRET, which is dropped
        if (exc_valid) begin
          state_nxt = ST_ENTER;
          cause_nxt = {27'b0, exc_cause};
        end else if (mret) begin
          state_nxt = ST_RETURN;
        end else if (insn_boundary && irq_en && irq_any) begin
          state_nxt = ST_ENTER;
          cause_nxt = irq_cause(irq_code);
        end
      end
      ST_ENTER:  state_nxt = ST_VECTOR;
      ST_VECTOR: state_nxt = ST_IDLE;
      ST_RETURN: state_nxt = ST_RESUME;
      ST_RESUME: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered by decoding the next state, so each pulse lines
  // up with the cycle the FSM spends in the corresponding state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      trap_cause   <= 32'h0;
      trap_start   <= 1'b0;
      trap_finish  <= 1'b0;
      redirect     <= 1'b0;
      redirect_sel <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      trap_cause   <= cause_nxt;
      trap_start   <= (state_nxt == ST_ENTER);
      trap_finish  <= (state_nxt == ST_RETURN);
      redirect     <= (state_nxt == ST_VECTOR) || (state_nxt == ST_RESUME);
      redirect_sel <= (state_nxt == ST_RESUME);
      busy         <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  localparam int SYNC = 2;
  localparam int HMAX = 8192;

  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_FIN   = 2'd1;
  localparam logic [1:0] K_REDIR = 2'd2;

  typedef struct {
    int         stamp;
    logic [1:0] kind;
    logic       sel;
  } ev_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        ext_irq = 0, sw_irq = 0, timer_irq = 0, irq_en = 0;
  logic        insn_boundary = 0, exc_valid = 0, mret = 0;
  logic [4:0]  exc_cause = 0;
  logic        trap_start, trap_finish, redirect, redirect_sel, busy;
  logic [31:0] trap_cause;

  trap_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_irq       (ext_irq),
    .sw_irq        (sw_irq),
    .timer_irq     (timer_irq),
    .irq_en        (irq_en),
    .insn_boundary (insn_boundary),
    .exc_valid     (exc_valid),
    .exc_cause     (exc_cause),
    .mret          (mret),
    .trap_start    (trap_start),
    .trap_finish   (trap_finish),
    .trap_cause    (trap_cause),
    .redirect      (redirect),
    .redirect_sel  (redirect_sel),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: cycle-stamped expected pulses, the window in
  // which the sequencer is busy, the mcause history and the ext_irq history.
  ev_t         q[$];
  int          busy_from = 0, idle_at = 0;
  logic [31:0] cause_prev = 0, cause_cur = 0;
  int          cause_from = 0;
  int          last_rst = 0;
  bit          xh[HMAX];
  bit          ext_l = 0, sw_l = 0, tm_l = 0, en_l = 0;
  bit          mon_on = 0, do_final = 0;
  int          checks = 0, errors = 0;

  function automatic logic [31:0] cause_at(input int c);
    return (c >= cause_from) ? cause_cur : cause_prev;
  endfunction

  // ext_irq as seen by the arbiter in cycle c: the level driven SYNC cycles
  // earlier, provided that sample was taken after the last reset.
  function automatic bit ext_seen(input int c);
    int k;
    k = c - SYNC;
    if (k >= last_rst + 1 && k >= 0) return xh[k % HMAX];
    return 1'b0;
  endfunction

  task automatic enter(input int c, input logic [31:0] cz);
    q.push_back('{c + 1, K_START, 1'b0});
    q.push_back('{c + 2, K_REDIR, 1'b0});
    cause_prev = cause_at(c);
    cause_cur  = cz;
    cause_from = c + 1;
    busy_from  = c + 1;
    idle_at    = c + 3;
  endtask

  // Drive one cycle of stimulus and advance the model. Pulses are masked
  // while the model says the sequencer is busy, as the control unit would.
  task automatic tick(input bit r, input bit bnd, input bit exc,
                      input logic [4:0] cz, input bit mr);
    int c;
    bit bz;
    int code;
    @(posedge clk);
    #1;
    c  = cyc;
    bz = (busy_from <= c) && (c < idle_at);
    rst           = r;
    ext_irq       = ext_l;
    sw_irq        = sw_l;
    timer_irq     = tm_l;
    irq_en        = en_l;
    insn_boundary = bnd && !bz && !r;
    exc_valid     = exc && !bz && !r;
    exc_cause     = cz;
    mret          = mr && !bz && !r;
    xh[c % HMAX]  = ext_l;
    if (r) begin
      while (q.size() > 0 && q[$].stamp > c) void'(q.pop_back());
      if (idle_at > c + 1) idle_at = c + 1;
      cause_prev = cause_at(c);
      cause_cur  = 32'h0;
      cause_from = c + 1;
      last_rst   = c;
    end else if (!bz) begin
      if (exc_valid) begin
        enter(c, {27'b0, cz});
      end else if (mret) begin
        q.push_back('{c + 1, K_FIN, 1'b0});
        q.push_back('{c + 2, K_REDIR, 1'b1});
        busy_from = c + 1;
        idle_at   = c + 3;
      end else if (bnd && en_l && (ext_seen(c) || sw_l || tm_l)) begin
        if (ext_seen(c)) code = 11;
        else if (sw_l)   code = 3;
        else             code = 7;
        enter(c, 32'h8000_0000 + code);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 5'd0, 0);
  endtask

  // Monitor: pop whatever the model expects this cycle and compare against
  // every pulse, busy and trap_cause.
  always @(negedge clk) begin
    ev_t e;
    bit  es, ef, er, esel;
    if (mon_on) begin
      es = 0; ef = 0; er = 0; esel = 0;
      while (q.size() > 0 && q[0].stamp < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL stale_event cyc=%0d kind=%0d stamp=%0d never matched", cyc, e.kind, e.stamp);
      end
      if (q.size() > 0 && q[0].stamp == cyc) begin
        e = q.pop_front();
        es = (e.kind == K_START);
        ef = (e.kind == K_FIN);
        er = (e.kind == K_REDIR);
        esel = e.sel;
      end
      checks++;
      if ({trap_start, trap_finish, redirect} !== {es, ef, er}) begin
        errors++;
        $display("FAIL pulses cyc=%0d got start/finish/redirect=%b%b%b want %b%b%b",
                 cyc, trap_start, trap_finish, redirect, es, ef, er);
      end
      if (er) begin
        checks++;
        if (redirect_sel !== esel) begin
          errors++;
          $display("FAIL redirect_sel cyc=%0d got %b want %b", cyc, redirect_sel, esel);
        end
      end
      checks++;
      if (busy !== ((busy_from <= cyc) && (cyc < idle_at))) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b want %b", cyc, busy,
                 (busy_from <= cyc) && (cyc < idle_at));
      end
      checks++;
      if (trap_cause !== cause_at(cyc)) begin
        errors++;
        $display("FAIL trap_cause cyc=%0d got %h want %h", cyc, trap_cause, cause_at(cyc));
      end
      if (do_final) begin
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL drain cyc=%0d got %0d pending events want 0", cyc, q.size());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      assert (!(busy && (exc_valid || mret)))
        else $error("exc_valid/mret driven while busy at cyc %0d", cyc);
    end
  end

  initial begin
    repeat (3) tick(1, 0, 0, 5'd0, 0);
    tick(0, 0, 0, 5'd0, 0);
    mon_on = 1;
    idle(5);

    // Exception, illegal instruction
    tick(0, 0, 1, 5'd2, 0);
    idle(4);

    // Interrupt priority: all three, then sw+timer, then timer only
    ext_l = 1; sw_l = 1; tm_l = 1; en_l = 1;
    idle(SYNC + 1);
    tick(0, 1, 0, 5'd0, 0); idle(4);
    ext_l = 0;
    idle(SYNC + 1);
    tick(0, 1, 0, 5'd0, 0); idle(4);
    sw_l = 0;
    tick(0, 1, 0, 5'd0, 0); idle(4);

    // Gating by irq_en
    en_l = 0;
    repeat (5) begin tick(0, 1, 0, 5'd0, 0); idle(1); end
    en_l = 1;
    tick(0, 1, 0, 5'd0, 0); idle(4);
    tm_l = 0;

    // MRET alone, then MRET colliding with an exception
    tick(0, 0, 0, 5'd0, 1); idle(4);
    tick(0, 0, 1, 5'd3, 1); idle(4);

    // Reset while in ENTER
    tick(0, 0, 1, 5'd2, 0);
    tick(1, 0, 0, 5'd0, 0);
    idle(4);

    // ext_irq rising straight after reset, boundary every cycle
    tick(1, 0, 0, 5'd0, 0);
    ext_l = 1;
    repeat (8) tick(0, 1, 0, 5'd0, 0);
    ext_l = 0;
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)  ext_l = ~ext_l;
      if ($urandom_range(0, 7) == 0)  sw_l  = ~sw_l;
      if ($urandom_range(0, 7) == 0)  tm_l  = ~tm_l;
      if ($urandom_range(0, 15) == 0) en_l  = ~en_l;
      tick($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 11) == 0, 5'($urandom_range(0, 31)),
           $urandom_range(0, 11) == 0);
    end
    ext_l = 0; sw_l = 0; tm_l = 0;
    idle(6);

    do_final = 1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
